// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter.
//   arb_state_e : arbiter FSM encoding (ARB_IDLE, ARB_LOCKED)
//   rr_select() : round-robin pick, first set request at or after ptr (mod num_ports)
package axis_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned RR_MAX_PORTS = 16;
  localparam int unsigned RR_IDX_W     = 4;

  // Request vectors narrower than RR_MAX_PORTS are zero-extended by the caller.
  function automatic logic [RR_IDX_W-1:0] rr_select(
    input logic [RR_MAX_PORTS-1:0] req,
    input logic [RR_IDX_W-1:0]     ptr,
    input int unsigned             num_ports
  );
    logic [RR_IDX_W-1:0] sel;
    logic                found;
    logic [RR_IDX_W:0]   idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_PORTS; i++) begin
      idx = (RR_IDX_W+1)'(ptr) + (RR_IDX_W+1)'(i);
      if (idx >= (RR_IDX_W+1)'(num_ports)) idx = idx - (RR_IDX_W+1)'(num_ports);
      if (!found && (i < num_ports) && req[idx[RR_IDX_W-1:0]]) begin
        sel   = idx[RR_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Generic 2-entry AXI-Stream buffer with registered outputs.
//   aclk, aresetn     : clock, async active-low reset
//   s_data/s_valid/s_ready : upstream side; s_ready = fewer than 2 entries held
//   m_data/m_valid/m_ready : downstream side; presents the oldest entry
module axis_skid2 #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic             valid_q, valid_d, full_q, full_d;
  logic             push, pop;

  assign push    = s_valid && !full_q;
  assign pop     = valid_q && m_ready;
  assign s_ready = !full_q;
  assign m_data  = head_q;
  assign m_valid = valid_q;

  // Occupancy update: head always holds the oldest entry, tail the second.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    full_d  = full_q;
    if (!valid_q) begin
      if (push) begin
        head_d  = s_data;
        valid_d = 1'b1;
      end
    end else if (!full_q) begin
      unique case ({push, pop})
        2'b10: begin
          tail_d = s_data;
          full_d = 1'b1;
        end
        2'b01:   valid_d = 1'b0;
        2'b11:   head_d  = s_data;
        default: ;
      endcase
    end else if (pop) begin
      head_d = tail_q;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-atomic round-robin arbiter: NUM_PORTS AXI-Stream slaves onto one master.
// A grant is held from first beat to tlast; one IDLE cycle separates packets.
//   aclk, aresetn       : clock, async active-low reset
//   enable              : allow new grants (sampled only in IDLE)
//   s_axis_*            : per-port slave streams, port i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_*            : arbitrated stream, registered through a 2-entry skid buffer
//   m_axis_tid          : source port index (only with AXIS_ARB_TID_EN defined)
//   busy                : high while a packet is locked
// Optional feature macro: AXIS_ARB_TID_EN
module axis_pkt_arbiter
  import axis_pkg::*;
#(
  parameter  int unsigned NUM_PORTS  = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned IDX_W      = $clog2(NUM_PORTS)
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            enable,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
`ifdef AXIS_ARB_TID_EN
  output logic [IDX_W-1:0]                m_axis_tid,
`endif
  output logic                            busy
);

`ifdef AXIS_ARB_TID_EN
  localparam int unsigned PAY_W = DATA_WIDTH + 1 + IDX_W;
`else
  localparam int unsigned PAY_W = DATA_WIDTH + 1;
`endif

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic                    skid_ready;
  logic                    in_valid, in_last, in_hs;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [PAY_W-1:0]        in_pay, out_pay;

  // Input mux from the granted port.
  assign in_valid = (state_q == ARB_LOCKED) && s_axis_tvalid[grant_q];
  assign in_last  = s_axis_tlast[grant_q];
  assign in_data  = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign in_hs    = in_valid && skid_ready;
  assign busy     = (state_q == ARB_LOCKED);

  // Only the granted port sees ready, and only while the buffer has room.
  always_comb begin
    s_axis_tready = '0;
    if (state_q == ARB_LOCKED) s_axis_tready[grant_q] = skid_ready;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (enable && |s_axis_tvalid) begin
          grant_d = IDX_W'(rr_select(RR_MAX_PORTS'(s_axis_tvalid),
                                     RR_IDX_W'(rr_ptr_q), NUM_PORTS));
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (in_hs && in_last) begin
          rr_ptr_d = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef AXIS_ARB_TID_EN
  assign in_pay = {grant_q, in_last, in_data};
  assign {m_axis_tid, m_axis_tlast, m_axis_tdata} = out_pay;
`else
  assign in_pay = {in_last, in_data};
  assign {m_axis_tlast, m_axis_tdata} = out_pay;
`endif

  axis_skid2 #(
    .WIDTH (PAY_W)
  ) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_data  (in_pay),
    .s_valid (in_valid),
    .s_ready (skid_ready),
    .m_data  (out_pay),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for axis_pkt_arbiter (4 ports x 32 bits).
module tb_axis_pkt_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic              enable;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP-1:0]     s_tvalid, s_tready, s_tlast;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tready, m_tlast, busy;
`ifdef AXIS_ARB_TID_EN
  logic [1:0]        m_tid;
`endif

  always #5 aclk = ~aclk;

  axis_pkt_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .enable        (enable),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
`ifdef AXIS_ARB_TID_EN
    .m_axis_tid    (m_tid),
`endif
    .busy          (busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [31:0] cyc;
  } beat_t;

  logic [32:0]  srcq [NP][$];
  beat_t        outq [$];
  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  int unsigned  cyc = 0;
  int unsigned  n0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present each port's queue head; a port is valid while its queue is non-empty.
  task automatic drive();
    for (int unsigned i = 0; i < NP; i++) begin
      if (aresetn && srcq[i].size() != 0) begin
        s_tvalid[i] = 1'b1;
        {s_tlast[i], s_tdata[i*DW +: DW]} = srcq[i][0];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
        s_tdata[i*DW +: DW] = '0;
      end
    end
  endtask

  // Sample handshakes mid-cycle, then advance one clock and re-drive.
  task automatic tick();
    @(negedge aclk);
    check("tready_onehot0", 64'($onehot0(s_tready)), 64'd1);
    for (int unsigned i = 0; i < NP; i++)
      if (s_tvalid[i] && s_tready[i]) void'(srcq[i].pop_front());
    if (m_tvalid && m_tready) outq.push_back('{m_tdata, m_tlast, 32'(cyc)});
    @(posedge aclk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic wait_out(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned k;
    k = 0;
    while (outq.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(outq.size() >= n), 64'd1);
  endtask

  task automatic load(input int unsigned p, input logic [31:0] base, input int unsigned n);
    for (int unsigned k = 0; k < n; k++)
      srcq[p].push_back({(k == n - 1), base + 32'(k)});
  endtask

  task automatic reset_dut();
    aresetn  = 1'b0;
    enable   = 1'b1;
    m_tready = 1'b1;
    for (int unsigned p = 0; p < NP; p++) srcq[p].delete();
    outq.delete();
    drive();
    tick();
    tick();
    aresetn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn  = 1'b1;
    enable   = 1'b1;
    m_tready = 1'b1;
    drive();
    #2 aresetn = 1'b0;
    #1;
    // Reset values
    check("rst_tready", 64'(s_tready), 64'd0);
    check("rst_mvalid", 64'(m_tvalid), 64'd0);
    check("rst_mlast",  64'(m_tlast),  64'd0);
    check("rst_busy",   64'(busy),     64'd0);
    reset_dut();

    // 1: port 2, 3-beat packet, latency and ordering
    load(2, 32'h0200_0000, 3);
    drive();
    check("t1_c0_busy", 64'(busy), 64'd0);
    tick();
    check("t1_c1_busy",   64'(busy),     64'd1);
    check("t1_c1_tready", 64'(s_tready), 64'b0100);
    check("t1_c1_mvalid", 64'(m_tvalid), 64'd0);
    tick();
    check("t1_c2_mvalid", 64'(m_tvalid), 64'd1);
    check("t1_c2_mdata",  64'(m_tdata),  64'h0200_0000);
    check("t1_c2_mlast",  64'(m_tlast),  64'd0);
    tick();
    check("t1_c3_mdata",  64'(m_tdata),  64'h0200_0001);
    tick();
    check("t1_c4_mdata",  64'(m_tdata),  64'h0200_0002);
    check("t1_c4_mlast",  64'(m_tlast),  64'd1);
    check("t1_c4_busy",   64'(busy),     64'd0);
    tick();
    check("t1_c5_mvalid", 64'(m_tvalid), 64'd0);
    check("t1_count",     64'(outq.size()), 64'd3);

    // 2: all ports, single-beat packets -> 0,1,2,3,... with one bubble
    reset_dut();
    for (int unsigned n = 0; n < 3; n++)
      for (int unsigned p = 0; p < NP; p++)
        load(p, (32'(p) << 24) | 32'(n), 1);
    drive();
    wait_out(12, 100, "t2_timeout");
    for (int unsigned k = 0; k < 12 && k < outq.size(); k++) begin
      check("t2_order", 64'(outq[k].data), 64'((32'(k % 4) << 24) | 32'(k / 4)));
      check("t2_last",  64'(outq[k].last), 64'd1);
      if (k > 0) check("t2_gap", 64'(outq[k].cyc - outq[k-1].cyc), 64'd2);
    end

    // 3: port 0 5-beat packet is atomic while port 1 waits
    outq.delete();
    load(0, 32'h1000_0000, 5);
    load(1, 32'h1100_0000, 2);
    drive();
    wait_out(7, 100, "t3_timeout");
    for (int unsigned k = 0; k < 7 && k < outq.size(); k++) begin
      check("t3_order", 64'(outq[k].data),
            (k < 5) ? 64'(32'h1000_0000 + 32'(k)) : 64'(32'h1100_0000 + 32'(k - 5)));
      check("t3_last", 64'(outq[k].last), 64'((k == 4) || (k == 6)));
    end

    // 4: downstream stall for 4 cycles mid-packet
    outq.delete();
    load(1, 32'h2000_0000, 6);
    drive();
    wait_out(2, 50, "t4_timeout_a");
    m_tready = 1'b0;
    check("t4_hold_valid", 64'(m_tvalid), 64'd1);
    check("t4_hold_data",  64'(m_tdata),  64'h2000_0002);
    n0 = srcq[1].size();
    repeat (4) begin
      tick();
      check("t4_stall_valid", 64'(m_tvalid), 64'd1);
      check("t4_stall_data",  64'(m_tdata),  64'h2000_0002);
      check("t4_stall_last",  64'(m_tlast),  64'd0);
    end
    check("t4_accepted_le2", 64'((n0 - srcq[1].size()) <= 2), 64'd1);
    check("t4_full_tready",  64'(s_tready), 64'd0);
    m_tready = 1'b1;
    wait_out(6, 50, "t4_timeout_b");
    check("t4_count", 64'(outq.size()), 64'd6);
    for (int unsigned k = 0; k < 6 && k < outq.size(); k++) begin
      check("t4_order", 64'(outq[k].data), 64'(32'h2000_0000 + 32'(k)));
      check("t4_last",  64'(outq[k].last), 64'(k == 5));
    end

    // 5: enable drops during beat 2 of a 4-beat packet on port 3
    outq.delete();
    load(3, 32'h3000_0000, 4);
    drive();
    tick();
    tick();
    enable = 1'b0;
    load(0, 32'h3F00_0000, 1);
    drive();
    repeat (8) tick();
    check("t5_count", 64'(outq.size()), 64'd4);
    for (int unsigned k = 0; k < 4 && k < outq.size(); k++)
      check("t5_order", 64'(outq[k].data), 64'(32'h3000_0000 + 32'(k)));
    check("t5_held_busy",   64'(busy),            64'd0);
    check("t5_held_tready", 64'(s_tready),        64'd0);
    check("t5_held_q",      64'(srcq[0].size()),  64'd1);
    enable = 1'b1;
    check("t5_en_busy0", 64'(busy), 64'd0);
    tick();
    check("t5_en_busy1",  64'(busy),     64'd1);
    check("t5_en_tready", 64'(s_tready), 64'b0001);
    wait_out(5, 20, "t5_timeout");
    if (outq.size() >= 5) check("t5_resume", 64'(outq[4].data), 64'h3F00_0000);

    // 6: reset mid-packet, round-robin pointer returns to 0
    outq.delete();
    load(2, 32'h4000_0000, 1);
    drive();
    wait_out(1, 20, "t6_timeout_a");
    load(2, 32'h4100_0000, 4);
    drive();
    wait_out(3, 20, "t6_timeout_b");
    check("t6_pre_valid", 64'(m_tvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    check("t6_rst_valid",  64'(m_tvalid), 64'd0);
    check("t6_rst_tready", 64'(s_tready), 64'd0);
    check("t6_rst_busy",   64'(busy),     64'd0);
    for (int unsigned p = 0; p < NP; p++) srcq[p].delete();
    outq.delete();
    drive();
    tick();
    tick();
    aresetn = 1'b1;
    load(1, 32'h5100_0000, 1);
    load(3, 32'h5300_0000, 1);
    drive();
    wait_out(2, 20, "t6_timeout_c");
    if (outq.size() >= 2) begin
      check("t6_first",  64'(outq[0].data), 64'h5100_0000);
      check("t6_second", 64'(outq[1].data), 64'h5300_0000);
    end
    tick();
    check("t6_end_valid", 64'(m_tvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
